// File: rtl/core_apb_arbiter.sv
// N-channel APB4 master front-end: arbitrates valid/ready requesters onto one APB port,
// with optional fixed-priority or round-robin selection and an ACCESS-phase timeout.
//
// state  | meaning
// IDLE   | no transfer; arbitrate and latch the winner's payload when any request is valid
// SETUP  | psel high, penable low; timeout counter cleared
// ACCESS | psel and penable high; complete on pready or on timeout terminal count
module core_apb_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 34,
  parameter int ARB_RR  = 1,
  parameter int TIMEOUT = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH-1:0]        req_write,
  input  logic [NUM_CH*32-1:0]     req_wdata,
  input  logic [NUM_CH*4-1:0]      req_wstrb,
  output logic [NUM_CH-1:0]        req_ready,
  output logic [31:0]              rsp_rdata,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     psel,
  output logic                     penable,
  output logic [ADDR_W-1:0]        paddr,
  output logic                     pwrite,
  output logic [31:0]              pwdata,
  output logic [3:0]               pwstrb,
  input  logic                     pready,
  input  logic [31:0]              prdata,
  input  logic                     pslverr
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] grant_q;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_found;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_hit;
  logic             grant_en;
  logic             xfer_done;

  // Candidate order starts at the RR pointer (or index 0 for fixed priority) and wraps.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    cand      = 0;
    cand_idx  = '0;
    arb_idx   = '0;
    arb_found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = (ARB_RR != 0) ? int'(rr_ptr_q) + k : k;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      cand_idx = IDX_W'(cand);
      if (!arb_found && req_valid[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign grant_en    = (state_q == S_IDLE) && arb_found;
  assign xfer_done   = (state_q == S_ACCESS) && (pready || timeout_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (arb_found) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (pready || timeout_hit) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    busy      = (state_q != S_IDLE);
    if (state_q == S_ACCESS) begin
      if (pready) begin
        req_ready[grant_q] = 1'b1;
        rsp_rdata          = pwrite ? 32'h0 : prdata;
        rsp_err            = pslverr;
      end else if (timeout_hit) begin
        req_ready[grant_q] = 1'b1;
        rsp_err            = 1'b1;
      end
    end
  end

  // APB outputs are latched once at grant and cleared on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psel     <= 1'b0;
      penable  <= 1'b0;
      paddr    <= '0;
      pwrite   <= 1'b0;
      pwdata   <= '0;
      pwstrb   <= '0;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else if (grant_en) begin
      psel    <= 1'b1;
      penable <= 1'b0;
      paddr   <= req_addr[arb_idx*ADDR_W +: ADDR_W];
      pwrite  <= req_write[arb_idx];
      pwdata  <= req_wdata[arb_idx*32 +: 32];
      pwstrb  <= req_write[arb_idx] ? req_wstrb[arb_idx*4 +: 4] : 4'h0;
      grant_q <= arb_idx;
      if (ARB_RR != 0)
        rr_ptr_q <= (arb_idx == IDX_W'(NUM_CH - 1)) ? '0 : arb_idx + 1'b1;
    end else if (xfer_done) begin
      psel    <= 1'b0;
      penable <= 1'b0;
      paddr   <= '0;
      pwrite  <= 1'b0;
      pwdata  <= '0;
      pwstrb  <= '0;
    end else if (state_q == S_SETUP) begin
      penable <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt_q <= '0;
    else if (state_q == S_SETUP)    cnt_q <= '0;
    else if (state_q == S_ACCESS)   cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: tb/tb_core_apb_arbiter.sv
// Directed bench for core_apb_arbiter: a round-robin/timeout instance driven through a
// vector table, plus a fixed-priority instance checked during the arbitration sequence.
module tb_core_apb_arbiter;

  localparam int NC = 4;
  localparam int AW = 34;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NC-1:0]   req_valid;
  logic [NC*AW-1:0] req_addr;
  logic [NC-1:0]   req_write;
  logic [NC*32-1:0] req_wdata;
  logic [NC*4-1:0] req_wstrb;
  logic            pready;
  logic [31:0]     prdata;
  logic            pslverr;

  logic [NC-1:0] a_req_ready, b_req_ready;
  logic [31:0]   a_rsp_rdata, b_rsp_rdata;
  logic          a_rsp_err, b_rsp_err, a_busy, b_busy;
  logic          a_psel, b_psel, a_penable, b_penable, a_pwrite, b_pwrite;
  logic [AW-1:0] a_paddr, b_paddr;
  logic [31:0]   a_pwdata, b_pwdata;
  logic [3:0]    a_pwstrb, b_pwstrb;
  logic          b_pready = 1'b1;
  logic [31:0]   b_prdata = 32'h0;
  logic          b_pslverr = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  core_apb_arbiter #(.NUM_CH(NC), .ADDR_W(AW), .ARB_RR(1), .TIMEOUT(8)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_ready(a_req_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err), .busy(a_busy),
    .psel(a_psel), .penable(a_penable), .paddr(a_paddr), .pwrite(a_pwrite),
    .pwdata(a_pwdata), .pwstrb(a_pwstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  core_apb_arbiter #(.NUM_CH(NC), .ADDR_W(AW), .ARB_RR(0), .TIMEOUT(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_ready(b_req_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .busy(b_busy),
    .psel(b_psel), .penable(b_penable), .paddr(b_paddr), .pwrite(b_pwrite),
    .pwdata(b_pwdata), .pwstrb(b_pwstrb), .pready(b_pready), .prdata(b_prdata), .pslverr(b_pslverr)
  );

  typedef struct {
    int          ch;
    logic        wr;
    logic [33:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] prdata;
    logic        slverr;
    int          pready_at;   // ACCESS cycle index where pready rises; -1 = never
    int          done_at;     // ACCESS cycle index of the expected req_ready pulse
    bit          drop;        // drop req_valid right after grant
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_pwstrb;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Entered and left at a negedge with the DUT in IDLE.
  task automatic run_vec(input vec_t v);
    logic [3:0]  oh;
    logic [70:0] exp_pl;
    oh = 4'b0001 << v.ch;
    exp_pl = {v.addr, v.wr, v.wdata, v.exp_pwstrb};
    req_valid[v.ch]           = 1'b1;
    req_write[v.ch]           = v.wr;
    req_addr[v.ch*AW +: AW]   = v.addr;
    req_wdata[v.ch*32 +: 32]  = v.wdata;
    req_wstrb[v.ch*4 +: 4]    = v.wstrb;
    pready  = 1'b0;
    pslverr = v.slverr;
    prdata  = v.prdata;
    #1 chk("idle_psel", {a_psel, a_busy}, 2'b00);
    @(negedge clk);
    chk("setup_ctrl", {a_psel, a_penable, a_busy}, 3'b101);
    chk("setup_payload", {a_paddr, a_pwrite, a_pwdata, a_pwstrb}, exp_pl);
    req_addr[v.ch*AW +: AW]  = ~v.addr;
    req_wdata[v.ch*32 +: 32] = ~v.wdata;
    req_wstrb[v.ch*4 +: 4]   = ~v.wstrb;
    req_write[v.ch]          = ~v.wr;
    if (v.drop) req_valid[v.ch] = 1'b0;
    for (int w = 0; w <= v.done_at; w++) begin
      @(posedge clk);
      #1 pready = (w == v.pready_at);
      @(negedge clk);
      chk("access_ctrl", {a_psel, a_penable, a_busy}, 3'b111);
      chk("access_hold", {a_paddr, a_pwrite, a_pwdata, a_pwstrb}, exp_pl);
      if (w == v.done_at) begin
        chk("done_ready", a_req_ready, oh);
        chk("done_rsp", {a_rsp_rdata, a_rsp_err}, {v.exp_rdata, v.exp_err});
      end else begin
        chk("wait_ready", a_req_ready, 4'b0000);
      end
    end
    req_valid[v.ch] = 1'b0;
    @(posedge clk);
    #1 pready = 1'b0;
    @(negedge clk);
    chk("idle_after", {a_psel, a_penable, a_busy, a_req_ready, a_paddr, a_pwrite, a_pwdata, a_pwstrb}, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_order[5];
    rr_order = '{0, 1, 2, 3, 0};

    vecs[0] = '{1, 1'b0, 34'h0_1000_0000, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0,  0, 0, 1'b0, 32'hDEADBEEF, 1'b0, 4'h0};
    vecs[1] = '{0, 1'b1, 34'h2_0000_0040, 32'h12345678, 4'h3, 32'hAAAA5555, 1'b0,  4, 4, 1'b0, 32'h0,        1'b0, 4'h3};
    vecs[2] = '{2, 1'b0, 34'h1_2345_6788, 32'hFFFF0000, 4'hF, 32'hCAFEF00D, 1'b0,  1, 1, 1'b1, 32'hCAFEF00D, 1'b0, 4'h0};
    vecs[3] = '{3, 1'b0, 34'h0_0000_0100, 32'h0,        4'h0, 32'h11111111, 1'b0, -1, 7, 1'b0, 32'h0,        1'b1, 4'h0};
    vecs[4] = '{1, 1'b0, 34'h0_0000_0200, 32'h0,        4'h0, 32'h77777777, 1'b0,  7, 7, 1'b0, 32'h77777777, 1'b0, 4'h0};
    vecs[5] = '{0, 1'b0, 34'h3_0000_0000, 32'h0,        4'h0, 32'h0BADBAD0, 1'b1,  0, 0, 1'b0, 32'h0BADBAD0, 1'b1, 4'h0};
    vecs[6] = '{3, 1'b0, 34'h0_0000_0300, 32'h0,        4'h0, 32'h5A5A5A5A, 1'b0,  0, 0, 1'b0, 32'h5A5A5A5A, 1'b0, 4'h0};
    vecs[7] = '{2, 1'b1, 34'h3_FFFF_FFFC, 32'h89ABCDEF, 4'hC, 32'h13572468, 1'b1,  2, 2, 1'b0, 32'h0,        1'b1, 4'hC};
    vecs[8] = '{1, 1'b1, 34'h0_0000_0004, 32'h0000A5A5, 4'hF, 32'h0,        1'b0, -1, 7, 1'b0, 32'h0,        1'b1, 4'hF};

    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_write = '0;
    req_wdata = '0;
    req_wstrb = '0;
    pready    = 1'b0;
    prdata    = '0;
    pslverr   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rr_outputs", {a_psel, a_penable, a_paddr, a_pwrite, a_pwdata, a_pwstrb,
                             a_req_ready, a_rsp_rdata, a_rsp_err, a_busy}, '0);
    chk("reset_fp_outputs", {b_psel, b_penable, b_paddr, b_pwrite, b_pwdata, b_pwstrb,
                             b_req_ready, b_rsp_rdata, b_rsp_err, b_busy}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // All channels requesting continuously: RR rotates, fixed priority always picks ch0.
    rst_n = 1'b0;
    @(negedge clk);
    for (int c = 0; c < NC; c++) begin
      req_addr[c*AW +: AW] = 34'h0_0000_1000 + AW'(c * 16);
      req_wdata[c*32 +: 32] = 32'h0;
      req_wstrb[c*4 +: 4]   = 4'h0;
    end
    req_write = '0;
    req_valid = 4'hF;
    pready    = 1'b1;
    prdata    = 32'h0000CAFE;
    pslverr   = 1'b0;
    rst_n     = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      @(negedge clk);
      chk("rr_grant", a_req_ready, 4'b0001 << rr_order[k]);
      chk("rr_paddr", a_paddr, 34'h0_0000_1000 + AW'(rr_order[k] * 16));
      chk("fp_grant", b_req_ready, 4'b0001);
      @(negedge clk);
    end
    req_valid = '0;
    pready    = 1'b0;
    @(negedge clk);

    // Reset in the middle of ACCESS aborts the transfer and returns the RR pointer to 0.
    req_valid = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_access", {a_psel, a_penable}, 2'b11);
    #2 rst_n = 1'b0;
    #1 chk("reset_abort", {a_psel, a_penable, a_busy, a_req_ready}, '0);
    pready = 1'b1;
    #1 chk("reset_no_ready", a_req_ready, 4'b0000);
    req_valid = 4'b1001;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_setup", {a_psel, a_penable}, 2'b10);
    @(negedge clk);
    chk("post_reset_ptr0", a_req_ready, 4'b0001);
    req_valid = '0;
    pready    = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
